// File: rtl/bmc_soft_pipe.sv
// Soft-decision branch metric unit with valid/ready pipeline.
// Each trellis step: N_SYM soft symbols in, one distance metric per candidate codeword out.
// Optional macro BMC_MIN_NORM_EN adds a third stage that subtracts the minimum metric from every codeword.

// Per-symbol distance to an expected '0' and to an expected '1'; erased symbols contribute nothing.
module bmc_sym_dist #(
    parameter int SW = 3
) (
    input  logic [SW-1:0] rx,
    input  logic          erase,
    output logic [SW-1:0] d0,
    output logic [SW-1:0] d1
);
    localparam logic [SW-1:0] MAXV = '1;

    assign d0 = erase ? '0 : rx;
    assign d1 = erase ? '0 : MAXV - rx;
endmodule

module bmc_soft_pipe #(
    parameter int SW    = 3,
    parameter int N_SYM = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [N_SYM*SW-1:0]                           rx_soft,
    input  logic [N_SYM-1:0]                              erase,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [(2**N_SYM)*(SW+$clog2(N_SYM))-1:0]      bm_out,
    output logic                                          out_last
);
    localparam int NCW = 2**N_SYM;
    localparam int MW  = SW + $clog2(N_SYM);

    logic [N_SYM-1:0][SW-1:0] rx_a;
    logic [N_SYM-1:0][SW-1:0] d0_c, d1_c;

    assign rx_a = rx_soft;

    for (genvar g = 0; g < N_SYM; g++) begin : g_sym
        bmc_sym_dist #(.SW(SW)) u_dist (
            .rx    (rx_a[g]),
            .erase (erase[g]),
            .d0    (d0_c[g]),
            .d1    (d1_c[g])
        );
    end

    // S1: per-symbol distances
    logic                     s1_valid, s1_last, s1_moves;
    logic [N_SYM-1:0][SW-1:0] s1_d0, s1_d1;
    // S2: per-codeword sums
    logic                     s2_valid, s2_last, s2_moves, s2_en;
    logic [NCW-1:0][MW-1:0]   s2_bm, sum_c;

    assign s1_moves = s1_valid & (!s2_valid | s2_moves);
    assign in_ready = !s1_valid | s1_moves;
    assign s2_en    = !s2_valid | s2_moves;

    // S1 captures distances only on an accepted input; bubbles keep old data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_d0    <= '0;
            s1_d1    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                s1_d0   <= d0_c;
                s1_d1   <= d1_c;
            end
        end
    end

    // Codeword c picks d1 for symbol i when bit i of c is set, d0 otherwise
    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NCW; c++) begin
            for (int i = 0; i < N_SYM; i++) begin
                if (((c >> i) & 1) != 0)
                    sum_c[c] = sum_c[c] + MW'(s1_d1[i]);
                else
                    sum_c[c] = sum_c[c] + MW'(s1_d0[i]);
            end
        end
    end

    // S2 registers the raw sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_bm    <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_bm   <= sum_c;
            end
        end
    end

`ifdef BMC_MIN_NORM_EN
    // S3: min-normalised metrics, best codeword always 0
    logic                   s3_valid, s3_last, s3_moves;
    logic [NCW-1:0][MW-1:0] s3_bm;
    logic [MW-1:0]          min_c;

    assign s3_moves  = s3_valid & out_ready;
    assign s2_moves  = s2_valid & (!s3_valid | s3_moves);
    assign out_valid = s3_valid;
    assign out_last  = s3_last;
    assign bm_out    = s3_bm;

    // Minimum across all codeword sums held in S2
    always_comb begin
        min_c = s2_bm[0];
        for (int c = 1; c < NCW; c++)
            if (s2_bm[c] < min_c) min_c = s2_bm[c];
    end

    // S3 stores sums with the minimum removed; ties all land on 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_bm    <= '0;
        end else if (!s3_valid | s3_moves) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_last <= s2_last;
                for (int c = 0; c < NCW; c++)
                    s3_bm[c] <= s2_bm[c] - min_c;
            end
        end
    end
`else
    assign s2_moves  = s2_valid & out_ready;
    assign out_valid = s2_valid;
    assign out_last  = s2_last;
    assign bm_out    = s2_bm;
`endif

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Randomised + directed bench for bmc_soft_pipe against a behavioural metric model.
// Honours BMC_MIN_NORM_EN (expects 3-cycle latency and min-normalised metrics).
`timescale 1ns/1ps
module tb_bmc_soft_pipe;
    localparam int SW  = 3, NS  = 2, MW  = 4;
    localparam int SW2 = 2, NS2 = 3, MW2 = 4;
`ifdef BMC_MIN_NORM_EN
    localparam int LAT  = 3;
    localparam bit NORM = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit NORM = 1'b0;
`endif

    logic        clk = 1'b0, rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [5:0]  rx_soft;
    logic [1:0]  erase;
    logic [15:0] bm_out;
    logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_last2;
    logic [5:0]  rx_soft2;
    logic [2:0]  erase2;
    logic [31:0] bm_out2;

    int total = 0, bad = 0;
    int n_out1 = 0, n_out2 = 0;
    bit saw_nready = 1'b0, rnd_or = 1'b0;

    typedef struct { logic [63:0] bm; logic last; } exp_t;
    exp_t q1[$], q2[$];
    exp_t e1, e2, p1, p2;

    always #5 clk = ~clk;

    bmc_soft_pipe #(.SW(SW), .N_SYM(NS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rx_soft(rx_soft), .erase(erase), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .bm_out(bm_out), .out_last(out_last)
    );

    bmc_soft_pipe #(.SW(SW2), .N_SYM(NS2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .rx_soft(rx_soft2), .erase(erase2), .in_last(in_last2),
        .out_valid(out_valid2), .out_ready(out_ready2), .bm_out(bm_out2), .out_last(out_last2)
    );

    // Reference: Hamming-like soft distance summed over symbols, optionally minus the minimum
    function automatic logic [63:0] ref_vec(int sw, int ns, int mw, logic [31:0] rx, logic [3:0] er);
        int v[16];
        int maxv = (1 << sw) - 1;
        int mn;
        int r;
        logic [63:0] res = '0;
        for (int c = 0; c < (1 << ns); c++) begin
            v[c] = 0;
            for (int i = 0; i < ns; i++) begin
                r = int'((rx >> (i * sw)) & 32'(maxv));
                if (!er[i]) v[c] += (((c >> i) & 1) == 1) ? (maxv - r) : r;
            end
        end
        if (NORM) begin
            mn = v[0];
            for (int c = 1; c < (1 << ns); c++) if (v[c] < mn) mn = v[c];
            for (int c = 0; c < (1 << ns); c++) v[c] -= mn;
        end
        for (int c = 0; c < (1 << ns); c++) res |= 64'(v[c]) << (c * mw);
        return res;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Compare process for the main instance: scoreboard + stall stability
    logic        stall_prev = 1'b0;
    logic [15:0] held_bm;
    logic        held_last;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_bm", 64'(bm_out), 64'(held_bm));
                chk("stall_last", 64'(out_last), 64'(held_last));
            end
            if (!in_ready) saw_nready = 1'b1;
            if (in_valid && in_ready) begin
                e1.bm = ref_vec(SW, NS, MW, 32'(rx_soft), 4'(erase));
                e1.last = in_last;
                q1.push_back(e1);
            end
            if (out_valid && out_ready) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out: got bm %0h with no pending input", bm_out);
                end else begin
                    p1 = q1.pop_front();
                    chk("bm", 64'(bm_out), p1.bm);
                    chk("last", 64'(out_last), 64'(p1.last));
                end
                n_out1++;
            end
            stall_prev = out_valid && !out_ready;
            held_bm    = bm_out;
            held_last  = out_last;
        end
    end

    // Compare process for the SW=2, N_SYM=3 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid2 && in_ready2) begin
                e2.bm = ref_vec(SW2, NS2, MW2, 32'(rx_soft2), 4'(erase2));
                e2.last = in_last2;
                q2.push_back(e2);
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out2: got bm %0h with no pending input", bm_out2);
                end else begin
                    p2 = q2.pop_front();
                    chk("bm2", 64'(bm_out2), p2.bm);
                    chk("last2", 64'(out_last2), 64'(p2.last));
                end
                n_out2++;
            end
        end
    end

    // Random downstream backpressure
    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(logic [5:0] rx, logic [1:0] er, logic last);
        int w = 0;
        in_valid = 1'b1; rx_soft = rx; erase = er; in_last = last;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, want accept", w);
        end
        @(posedge clk); #1;
    endtask

    task automatic one_shot(string nm, logic [5:0] rx, logic [1:0] er, logic [15:0] raw, logic [15:0] nrm);
        int n;
        in_valid = 1'b1; rx_soft = rx; erase = er; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, "_lat"}, 64'(n), 64'(LAT));
        chk({nm, "_bm"}, 64'(bm_out), 64'(NORM ? nrm : raw));
        chk({nm, "_last"}, 64'(out_last), 64'd1);
        @(posedge clk); #1;
        chk({nm, "_pulse"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, want finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        rst = 1'b1; in_valid = 0; rx_soft = 0; erase = 0; in_last = 0; out_ready = 1;
        in_valid2 = 0; rx_soft2 = 0; erase2 = 0; in_last2 = 0; out_ready2 = 1;

        // Model pins from hand-worked examples
        chk("model_0_7", ref_vec(3, 2, 4, 32'd56, 4'd0), 64'h70E7);
        chk("model_3_4", ref_vec(3, 2, 4, 32'd35, 4'd0), NORM ? 64'h1021 : 64'h7687);
        chk("model_er01", ref_vec(3, 2, 4, 32'd21, 4'd1), NORM ? 64'h3300 : 64'h5522);
        chk("model_sw2_max", ref_vec(2, 3, 4, 32'd0, 4'd0), 64'h96636330);

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bm", 64'(bm_out), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Directed metric cases
        one_shot("d_0_7",  6'o70, 2'b00, 16'h70E7, 16'h70E7);
        one_shot("d_3_4",  6'o43, 2'b00, 16'h7687, 16'h1021);
        one_shot("d_er01", 6'o25, 2'b01, 16'h5522, 16'h3300);
        one_shot("d_er11", 6'o25, 2'b11, 16'h0000, 16'h0000);

        // Back-to-back 8 with a 5-cycle stall starting at cycle 3
        n0 = n_out1;
        saw_nready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(6'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0), k == 7);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("b2b_count", 64'(n_out1 - n0), 64'd8);
        chk("b2b_backpressure", 64'(saw_nready), 64'd1);
        chk("b2b_drained", 64'(q1.size()), 64'd0);

        // Randomised traffic with random backpressure
        rnd_or = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(6'($urandom), 2'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rnd_or = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("rand_drained", 64'(q1.size()), 64'd0);

        // Asynchronous reset with groups in flight
        out_ready = 1'b0;
        send(6'o16, 2'b00, 1'b0);
        send(6'o61, 2'b00, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        q1.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_bm", 64'(bm_out), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        one_shot("post_rst", 6'o43, 2'b00, 16'h7687, 16'h1021);

        // Exhaustive SW=2, N_SYM=3 sweep
        for (int r = 0; r < 64; r++) begin
            for (int e = 0; e < 8; e++) begin
                in_valid2 = 1'b1; rx_soft2 = 6'(r); erase2 = 3'(e);
                in_last2 = (r == 63 && e == 7);
                @(posedge clk); #1;
            end
        end
        in_valid2 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sweep_count", 64'(n_out2), 64'd512);
        chk("sweep_drained", 64'(q2.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
